// File: rtl/uart_tx_sequencer.sv
// Streams a block of bytes from the transmit buffer RAM into a UART TX core,
// one byte per tx_dv/tx_done handshake, with optional idle gap and abort on en_tx low.
module uart_tx_sequencer #(
  parameter int ADDR_W     = 15,
  parameter int GAP_CYCLES = 0,
  parameter int GAP_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en_tx,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_len,
  output logic [ADDR_W-1:0] o_r_address,
  output logic              o_rd_en,
  input  logic [7:0]        i_rd_data,
  output logic [7:0]        o_tx_byte,
  output logic              o_tx_dv,
  input  logic              i_tx_done,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_SEND = 3'd3,
    S_GAP  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  localparam bit                HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_address;
  logic              r_rd_en;
  logic [7:0]        r_tx_byte;
  logic              r_tx_dv;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;
  logic [ADDR_W:0]   r_remaining;
  logic [GAP_W-1:0]  r_gap_cnt;

  state_t            w_state_next;
  logic [ADDR_W-1:0] w_address_next;
  logic              w_rd_en_next;
  logic [7:0]        w_tx_byte_next;
  logic              w_tx_dv_next;
  logic              w_done_next;
  logic              w_aborted_next;
  logic [ADDR_W:0]   w_remaining_next;
  logic [GAP_W-1:0]  w_gap_cnt_next;
  logic              w_abort;
  logic              w_accept;

  // Abort outranks every other transition, including a coincident tx_done.
  assign w_abort  = (r_state != S_IDLE) && !i_en_tx;
  assign w_accept = (r_state == S_IDLE) && i_start && i_en_tx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_state_next = (i_len != '0) ? S_RD : S_FIN;
          end
        end
        S_RD:   w_state_next = S_CAP;
        S_CAP:  w_state_next = S_SEND;
        S_SEND: begin
          if (i_tx_done) begin
            if (r_remaining == LEN_ONE) begin
              w_state_next = S_FIN;
            end else if (HAS_GAP) begin
              w_state_next = S_GAP;
            end else begin
              w_state_next = S_RD;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_ONE) begin
            w_state_next = S_RD;
          end
        end
        S_FIN:   w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Next values for the registered outputs and counters; strobes default low.
  always_comb begin
    w_address_next   = r_address;
    w_rd_en_next     = 1'b0;
    w_tx_byte_next   = r_tx_byte;
    w_tx_dv_next     = 1'b0;
    w_done_next      = 1'b0;
    w_aborted_next   = 1'b0;
    w_remaining_next = r_remaining;
    w_gap_cnt_next   = r_gap_cnt;
    if (w_abort) begin
      w_address_next   = '0;
      w_aborted_next   = 1'b1;
      w_remaining_next = '0;
      w_gap_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && (i_len != '0)) begin
            w_address_next   = i_base_addr;
            w_remaining_next = i_len;
            w_rd_en_next     = 1'b1;
          end
        end
        S_CAP: begin
          w_tx_byte_next = i_rd_data;
          w_tx_dv_next   = 1'b1;
        end
        S_SEND: begin
          if (i_tx_done) begin
            w_remaining_next = r_remaining - LEN_ONE;
            if (r_remaining != LEN_ONE) begin
              if (HAS_GAP) begin
                w_gap_cnt_next = GAP_LOAD;
              end else begin
                w_address_next = r_address + ADDR_ONE;
                w_rd_en_next   = 1'b1;
              end
            end
          end
        end
        S_GAP: begin
          w_gap_cnt_next = r_gap_cnt - GAP_ONE;
          if (r_gap_cnt == GAP_ONE) begin
            w_address_next = r_address + ADDR_ONE;
            w_rd_en_next   = 1'b1;
          end
        end
        S_FIN: begin
          w_done_next = 1'b1;
        end
        default: begin
          w_done_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_address   <= '0;
      r_rd_en     <= 1'b0;
      r_tx_byte   <= '0;
      r_tx_dv     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_remaining <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_address   <= w_address_next;
      r_rd_en     <= w_rd_en_next;
      r_tx_byte   <= w_tx_byte_next;
      r_tx_dv     <= w_tx_dv_next;
      r_busy      <= (w_state_next != S_IDLE);
      r_done      <= w_done_next;
      r_aborted   <= w_aborted_next;
      r_remaining <= w_remaining_next;
      r_gap_cnt   <= w_gap_cnt_next;
    end
  end

  assign o_r_address = r_address;
  assign o_rd_en     = r_rd_en;
  assign o_tx_byte   = r_tx_byte;
  assign o_tx_dv     = r_tx_dv;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_aborted   = r_aborted;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: one instance without gap, one with a 5-cycle gap.
// Expected events (read, strobe, done, abort) carry a cycle offset from the start or last tx_done.
module tb_uart_tx_sequencer;

  localparam int K_RD   = 0;
  localparam int K_DV   = 1;
  localparam int K_DONE = 2;
  localparam int K_AB   = 3;
  localparam int R_S    = 0;
  localparam int R_D    = 1;

  typedef struct {
    int kind;
    int val;
    int refk;
    int off;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_tx;
  logic        start0, start5;
  logic [14:0] base_addr;
  logic [15:0] len;

  logic [14:0] addr0, addr5;
  logic        rd_en0, rd_en5;
  logic [7:0]  rd_data0, rd_data5;
  logic [7:0]  tx_byte0, tx_byte5;
  logic        tx_dv0, tx_dv5;
  logic        tx_done0, tx_done5;
  logic        busy0, busy5, done0, done5, aborted0, aborted5;

  logic        auto_done0, auto_done5, man_done0, uart_auto0;
  int          cnt0, cnt5;

  logic [7:0]  mem [0:32767];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          s_edge [2];
  int          d_edge [2];
  logic        pend [2];
  logic        bad [2];
  logic        busy_chk [2];
  logic [7:0]  held [2];
  ev_t         q0 [$];
  ev_t         q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_done0 = auto_done0 | man_done0;
  assign tx_done5 = auto_done5;

  uart_tx_sequencer #(.ADDR_W(15), .GAP_CYCLES(0), .GAP_W(16)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en_tx(en_tx), .i_start(start0),
    .i_base_addr(base_addr), .i_len(len), .o_r_address(addr0), .o_rd_en(rd_en0),
    .i_rd_data(rd_data0), .o_tx_byte(tx_byte0), .o_tx_dv(tx_dv0), .i_tx_done(tx_done0),
    .o_busy(busy0), .o_done(done0), .o_aborted(aborted0)
  );

  uart_tx_sequencer #(.ADDR_W(15), .GAP_CYCLES(5), .GAP_W(16)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en_tx(en_tx), .i_start(start5),
    .i_base_addr(base_addr), .i_len(len), .o_r_address(addr5), .o_rd_en(rd_en5),
    .i_rd_data(rd_data5), .o_tx_byte(tx_byte5), .o_tx_dv(tx_dv5), .i_tx_done(tx_done5),
    .o_busy(busy5), .o_done(done5), .o_aborted(aborted5)
  );

  // Buffer RAM: background pattern addr^0xA5, plus the "ABC" block at 0x10.
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = i[7:0] ^ 8'hA5;
    mem[16] = 8'h41;
    mem[17] = 8'h42;
    mem[18] = 8'h43;
  end

  always @(posedge clk) begin
    if (rd_en0) rd_data0 <= mem[addr0];
    if (rd_en5) rd_data5 <= mem[addr5];
  end

  // UART models: tx_done pulse 21 edges after each observed tx_dv.
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt0 <= 0; auto_done0 <= 1'b0; cnt5 <= 0; auto_done5 <= 1'b0;
    end else begin
      if (uart_auto0 && tx_dv0) cnt0 <= 20;
      else if (cnt0 != 0) cnt0 <= cnt0 - 1;
      auto_done0 <= uart_auto0 && (cnt0 == 1);
      if (tx_dv5) cnt5 <= 20;
      else if (cnt5 != 0) cnt5 <= cnt5 - 1;
      auto_done5 <= (cnt5 == 1);
    end
  end

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int d, input int k, input int v, input int r, input int o);
    ev_t e;
    e.kind = k; e.val = v; e.refk = r; e.off = o;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic observe(input int d, input int k, input int v);
    ev_t e;
    int  exp_cyc;
    checks++;
    if (qsize(d) == 0) begin
      failures++;
      $display("FAIL unexpected_event dut%0d kind=%0d val=%h cyc=%0d required none", d, k, v, cyc);
    end else begin
      if (d == 0) e = q0.pop_front();
      else e = q1.pop_front();
      exp_cyc = ((e.refk == R_S) ? s_edge[d] : d_edge[d]) + e.off;
      if (e.kind != k || e.val != v || cyc != exp_cyc) begin
        failures++;
        $display("FAIL event dut%0d actual kind=%0d val=%h cyc=%0d required kind=%0d val=%h cyc=%0d",
                 d, k, v, cyc, e.kind, e.val, exp_cyc);
      end else if (k == K_DV) begin
        $display("dut%0d tx byte=%h cyc=%0d", d, v, cyc);
      end else if (k == K_DONE || k == K_AB) begin
        $display("dut%0d transfer %s cyc=%0d", d, (k == K_DONE) ? "done" : "aborted", cyc);
      end
    end
  endtask

  task automatic mon(input int d, input logic rd, input logic [14:0] a, input logic dv,
                     input logic [7:0] b, input logic dn, input logic ab, input logic td,
                     input logic bz);
    if (busy_chk[d]) begin
      chk($sformatf("busy_after_end_dut%0d", d), {31'd0, bz}, 32'd0);
      busy_chk[d] = 1'b0;
    end
    if (rd) observe(d, K_RD, int'(a));
    if (dv) begin
      observe(d, K_DV, int'(b));
      held[d] = b; pend[d] = 1'b1; bad[d] = 1'b0;
    end else if (pend[d] && b != held[d]) begin
      bad[d] = 1'b1;
    end
    if (dn) begin observe(d, K_DONE, 0); busy_chk[d] = 1'b1; end
    if (ab) begin observe(d, K_AB, 0); busy_chk[d] = 1'b1; end
    if (td) begin
      d_edge[d] = cyc + 1;
      if (pend[d]) begin
        chk($sformatf("tx_byte_stable_dut%0d", d), {31'd0, bad[d]}, 32'd0);
        pend[d] = 1'b0;
      end
    end
    if (ab) pend[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      mon(0, rd_en0, addr0, tx_dv0, tx_byte0, done0, aborted0, tx_done0, busy0);
      mon(1, rd_en5, addr5, tx_dv5, tx_byte5, done5, aborted5, tx_done5, busy5);
    end
  end

  task automatic start_xfer(input int d, input logic [14:0] b, input logic [15:0] l);
    base_addr = b;
    len = l;
    if (d == 0) start0 = 1'b1;
    else start5 = 1'b1;
    s_edge[d] = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    start5 = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while (qsize(d) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain_dut%0d", d), qsize(d), 0);
    if (d == 0) q0.delete();
    else q1.delete();
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_dv0(input int budget);
    int n = 0;
    while (!tx_dv0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_tx_dv0", {31'd0, tx_dv0}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en_tx = 1'b1; start0 = 1'b0; start5 = 1'b0;
    base_addr = '0; len = '0; man_done0 = 1'b0; uart_auto0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; bad[i] = 1'b0; busy_chk[i] = 1'b0; held[i] = 8'h00;
      s_edge[i] = 0; d_edge[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_addr",    {17'd0, addr0}, 32'd0);
    chk("rst_rd_en",   {31'd0, rd_en0}, 32'd0);
    chk("rst_tx_dv",   {31'd0, tx_dv0}, 32'd0);
    chk("rst_tx_byte", {24'd0, tx_byte0}, 32'd0);
    chk("rst_busy",    {31'd0, busy0}, 32'd0);
    chk("rst_done",    {31'd0, done0}, 32'd0);
    chk("rst_aborted", {31'd0, aborted0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic three-byte transfer
    push(0, K_RD, 'h10, R_S, 0); push(0, K_DV, 'h41, R_S, 2);
    push(0, K_RD, 'h11, R_D, 0); push(0, K_DV, 'h42, R_D, 2);
    push(0, K_RD, 'h12, R_D, 0); push(0, K_DV, 'h43, R_D, 2);
    push(0, K_DONE, 0, R_D, 1);
    start_xfer(0, 15'h0010, 16'd3);
    wait_idle(0, 300);

    // Address wrap-around
    push(0, K_RD, 'h7FFE, R_S, 0); push(0, K_DV, 'h5B, R_S, 2);
    push(0, K_RD, 'h7FFF, R_D, 0); push(0, K_DV, 'h5A, R_D, 2);
    push(0, K_RD, 'h0000, R_D, 0); push(0, K_DV, 'hA5, R_D, 2);
    push(0, K_RD, 'h0001, R_D, 0); push(0, K_DV, 'hA4, R_D, 2);
    push(0, K_DONE, 0, R_D, 1);
    start_xfer(0, 15'h7FFE, 16'd4);
    wait_idle(0, 300);

    // Zero length: done one edge after the start edge, no RAM access
    push(0, K_DONE, 0, R_S, 1);
    start_xfer(0, 15'h0100, 16'd0);
    wait_idle(0, 20);

    // Start pulsed during SEND is ignored
    push(0, K_RD, 'h20, R_S, 0); push(0, K_DV, 'h85, R_S, 2);
    push(0, K_RD, 'h21, R_D, 0); push(0, K_DV, 'h84, R_D, 2);
    push(0, K_DONE, 0, R_D, 1);
    start_xfer(0, 15'h0020, 16'd2);
    repeat (6) @(negedge clk);
    base_addr = 15'h0050; len = 16'd7; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(0, 300);

    // Gap of 5 cycles: second read at D+5, second strobe at D+7
    push(1, K_RD, 'h30, R_S, 0); push(1, K_DV, 'h95, R_S, 2);
    push(1, K_RD, 'h31, R_D, 5); push(1, K_DV, 'h94, R_D, 7);
    push(1, K_DONE, 0, R_D, 1);
    start_xfer(1, 15'h0030, 16'd2);
    wait_idle(1, 300);

    // Abort during second SEND with a coincident tx_done
    uart_auto0 = 1'b0;
    push(0, K_RD, 'h70, R_S, 0); push(0, K_DV, 'hD5, R_S, 2);
    push(0, K_RD, 'h71, R_D, 0); push(0, K_DV, 'hD4, R_D, 2);
    push(0, K_AB, 0, R_D, 0);
    start_xfer(0, 15'h0070, 16'd4);
    wait_dv0(20);
    repeat (5) @(negedge clk);
    man_done0 = 1'b1;
    @(negedge clk);
    man_done0 = 1'b0;
    wait_dv0(20);
    repeat (3) @(negedge clk);
    en_tx = 1'b0;
    man_done0 = 1'b1;
    @(negedge clk);
    man_done0 = 1'b0;
    chk("abort_addr_zero", {17'd0, addr0}, 32'd0);
    repeat (3) @(negedge clk);
    en_tx = 1'b1;
    wait_idle(0, 50);
    uart_auto0 = 1'b1;

    // Normal transfer after abort
    push(0, K_RD, 'h12, R_S, 0); push(0, K_DV, 'h43, R_S, 2);
    push(0, K_DONE, 0, R_D, 1);
    start_xfer(0, 15'h0012, 16'd1);
    wait_idle(0, 300);

    // Asynchronous reset in the middle of GAP
    push(1, K_RD, 'h40, R_S, 0); push(1, K_DV, 'hE5, R_S, 2);
    start_xfer(1, 15'h0040, 16'd2);
    begin
      int n = 0;
      while (!tx_done5 && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("wait_tx_done5", {31'd0, tx_done5}, 32'd1);
    end
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("pre_reset_busy", {31'd0, busy5}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("areset_busy",  {31'd0, busy5}, 32'd0);
    chk("areset_tx_dv", {31'd0, tx_dv5}, 32'd0);
    chk("areset_rd_en", {31'd0, rd_en5}, 32'd0);
    chk("areset_addr",  {17'd0, addr5}, 32'd0);
    chk("areset_queue", qsize(1), 0);
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_reset_idle", {31'd0, busy5}, 32'd0);

    // Normal transfer after reset release
    push(1, K_RD, 'h60, R_S, 0); push(1, K_DV, 'hC5, R_S, 2);
    push(1, K_DONE, 0, R_D, 1);
    start_xfer(1, 15'h0060, 16'd1);
    wait_idle(1, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
